// File: rtl/intersection_ctrl_if.sv
// rtl/intersection_ctrl_if.sv - sensor and lamp bundle between the intersection controller and its datapath
//
// Signals:
//   ns_car, ew_car     vehicle presence sensors (level)
//   ped_req            pedestrian push-button (pulse)
//   northsouth_*       NS lamps (red/yellow/green)
//   eastwest_*         EW lamps (red/yellow/green)
//   walk               pedestrian walk indication
//   phase[2:0]         current controller state, for debug
// Modports:
//   master  the controller: samples sensors, drives lamps
//   slave   the datapath/bench: drives sensors, observes lamps

interface intersection_ctrl_if;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic       northsouth_red;
  logic       northsouth_yellow;
  logic       northsouth_green;
  logic       eastwest_red;
  logic       eastwest_yellow;
  logic       eastwest_green;
  logic       walk;
  logic [2:0] phase;

  modport master (
    input  ns_car, ew_car, ped_req,
    output northsouth_red, northsouth_yellow, northsouth_green,
    output eastwest_red, eastwest_yellow, eastwest_green,
    output walk, phase
  );

  modport slave (
    output ns_car, ew_car, ped_req,
    input  northsouth_red, northsouth_yellow, northsouth_green,
    input  eastwest_red, eastwest_yellow, eastwest_green,
    input  walk, phase
  );
endinterface

// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - sensor-actuated two-way intersection controller with pedestrian phase
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       intersection_ctrl_if.master: sensors in, lamps/walk/phase out

module intersection_ctrl #(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  intersection_ctrl_if.master  bus
);

  localparam int MAX_A = (GREEN_MIN > GREEN_MAX) ? GREEN_MIN : GREEN_MAX;
  localparam int MAX_B = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > WALK_TIME) ? MAX_C : WALK_TIME;
  localparam int TW    = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] T_WALK = TW'(WALK_TIME - 1);

  typedef enum logic [2:0] {
    NS_GREEN   = 3'd0,
    NS_YELLOW  = 3'd1,
    AR_TO_EW   = 3'd2,
    EW_GREEN   = 3'd3,
    EW_YELLOW  = 3'd4,
    AR_TO_NS   = 3'd5,
    WALK_TO_EW = 3'd6,
    WALK_TO_NS = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pending_q, ped_pending_d;
  logic          ns_go, ew_go, enter_walk, in_green;
  logic [2:0]    ns_lamp, ew_lamp;
  logic          walk_lamp;

  // A green ends once the minimum is served and someone is waiting on the
  // other side; own-direction traffic can extend it only up to the maximum.
  assign ns_go = (timer_q >= T_GMIN) && (bus.ew_car || ped_pending_q) &&
                 (!bus.ns_car || timer_q >= T_GMAX);
  assign ew_go = (timer_q >= T_GMIN) && (bus.ns_car || ped_pending_q) &&
                 (!bus.ew_car || timer_q >= T_GMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= AR_TO_NS;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:   if (ns_go)              state_d = NS_YELLOW;
      NS_YELLOW:  if (timer_q == T_YEL)   state_d = AR_TO_EW;
      AR_TO_EW:   if (timer_q == T_AR)    state_d = ped_pending_q ? WALK_TO_EW : EW_GREEN;
      EW_GREEN:   if (ew_go)              state_d = EW_YELLOW;
      EW_YELLOW:  if (timer_q == T_YEL)   state_d = AR_TO_NS;
      AR_TO_NS:   if (timer_q == T_AR)    state_d = ped_pending_q ? WALK_TO_NS : NS_GREEN;
      WALK_TO_EW: if (timer_q == T_WALK)  state_d = EW_GREEN;
      WALK_TO_NS: if (timer_q == T_WALK)  state_d = NS_GREEN;
      default:                            state_d = AR_TO_NS;
    endcase

    // Green timers hold at GREEN_MAX-1 so a resting green never wraps.
    in_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);
    if (state_d != state_q)
      timer_d = '0;
    else if (in_green && timer_q >= T_GMAX)
      timer_d = T_GMAX;
    else
      timer_d = timer_q + TW'(1);

    // A press arriving on the very edge that starts a walk is kept for the
    // next crossing rather than being absorbed by the current one.
    enter_walk    = (state_d != state_q) &&
                    (state_d == WALK_TO_EW || state_d == WALK_TO_NS);
    ped_pending_d = bus.ped_req || (ped_pending_q && !enter_walk);
  end

  // Lamps are a pure decode of the state register; {red, yellow, green}.
  always_comb begin
    ns_lamp   = 3'b100;
    ew_lamp   = 3'b100;
    walk_lamp = 1'b0;
    case (state_q)
      NS_GREEN:               ns_lamp   = 3'b001;
      NS_YELLOW:              ns_lamp   = 3'b010;
      EW_GREEN:               ew_lamp   = 3'b001;
      EW_YELLOW:              ew_lamp   = 3'b010;
      WALK_TO_EW, WALK_TO_NS: walk_lamp = 1'b1;
      default: ;
    endcase
  end

  assign bus.northsouth_red    = ns_lamp[2];
  assign bus.northsouth_yellow = ns_lamp[1];
  assign bus.northsouth_green  = ns_lamp[0];
  assign bus.eastwest_red      = ew_lamp[2];
  assign bus.eastwest_yellow   = ew_lamp[1];
  assign bus.eastwest_green    = ew_lamp[0];
  assign bus.walk              = walk_lamp;
  assign bus.phase             = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb/tb_intersection_ctrl.sv - self-checking bench for intersection_ctrl against a phase-duration model

module tb_intersection_ctrl;
  localparam int GREEN_MIN   = 4;
  localparam int GREEN_MAX   = 10;
  localparam int YELLOW_TIME = 2;
  localparam int ALLRED_TIME = 1;
  localparam int WALK_TIME   = 3;

  logic clk;
  logic reset_n;

  intersection_ctrl_if bus ();

  intersection_ctrl #(
    .GREEN_MIN  (GREEN_MIN),
    .GREEN_MAX  (GREEN_MAX),
    .YELLOW_TIME(YELLOW_TIME),
    .ALLRED_TIME(ALLRED_TIME),
    .WALK_TIME  (WALK_TIME)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Phase model: current phase, cycles spent in it (counting the current one),
  // and whether a pedestrian is waiting.
  int m_phase;
  int m_elapsed;
  bit m_pend;

  // Fixed-length phases: their length and successor (greens/all-reds decided by rule).
  int fixed_dur [8] = '{0, YELLOW_TIME, ALLRED_TIME, 0, YELLOW_TIME, ALLRED_TIME, WALK_TIME, WALK_TIME};
  int fixed_nxt [8] = '{0, 2, 0, 3, 5, 0, 3, 0};
  // Lamp colour per phase: 0 red, 1 yellow, 2 green.
  int ns_col [8] = '{2, 1, 0, 0, 0, 0, 0, 0};
  int ew_col [8] = '{0, 0, 0, 2, 1, 0, 0, 0};

  // Run-length record of the observed phase sequence.
  int rl_ph[$];
  int rl_len[$];
  int cur_ph;
  int cur_len;
  int exp_ph[$];
  int exp_ln[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] lamp3(input int col);
    case (col)
      2:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic int model_next(input int ph, input int el, input bit ns, input bit ew, input bit pend);
    bit own, opp;
    if (ph == 0 || ph == 3) begin
      own = (ph == 0) ? ns : ew;
      opp = ((ph == 0) ? ew : ns) | pend;
      if (el >= GREEN_MIN && opp && (!own || el >= GREEN_MAX)) return ph + 1;
      return ph;
    end
    if (ph == 2 || ph == 5) begin
      if (el < ALLRED_TIME) return ph;
      if (pend) return (ph == 2) ? 6 : 7;
      return (ph == 2) ? 3 : 0;
    end
    return (el >= fixed_dur[ph]) ? fixed_nxt[ph] : ph;
  endfunction

  task automatic model_reset();
    m_phase   = 5;
    m_elapsed = 1;
    m_pend    = 1'b0;
  endtask

  task automatic clear_runs();
    rl_ph.delete();
    rl_len.delete();
    cur_ph  = -1;
    cur_len = 0;
  endtask

  task automatic compare();
    logic [6:0] got_l, exp_l;
    logic [2:0] nsl, ewl;
    nsl   = {bus.northsouth_red, bus.northsouth_yellow, bus.northsouth_green};
    ewl   = {bus.eastwest_red, bus.eastwest_yellow, bus.eastwest_green};
    got_l = {nsl, ewl, bus.walk};
    exp_l = {lamp3(ns_col[m_phase]), lamp3(ew_col[m_phase]), (m_phase >= 6) ? 1'b1 : 1'b0};
    check("phase", int'(bus.phase), m_phase);
    check("lamps", int'(got_l), int'(exp_l));
    check("ns_onehot", int'($onehot(nsl)), 1);
    check("ew_onehot", int'($onehot(ewl)), 1);
    check("some_red", int'(nsl[2] | ewl[2]), 1);
    check("walk_both_red", int'(!bus.walk || (nsl[2] && ewl[2])), 1);
    if (int'(bus.phase) == cur_ph) cur_len++;
    else begin
      if (cur_len > 0) begin
        rl_ph.push_back(cur_ph);
        rl_len.push_back(cur_len);
      end
      cur_ph  = int'(bus.phase);
      cur_len = 1;
    end
  endtask

  task automatic cycle(input bit ns, input bit ew, input bit ped);
    int np;
    bus.ns_car  = ns;
    bus.ew_car  = ew;
    bus.ped_req = ped;
    np = model_next(m_phase, m_elapsed, ns, ew, m_pend);
    m_pend    = ped | (m_pend && !(np >= 6 && np != m_phase));
    m_elapsed = (np == m_phase) ? m_elapsed + 1 : 1;
    m_phase   = np;
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    bus.ns_car  = 1'b0;
    bus.ew_car  = 1'b0;
    bus.ped_req = 1'b0;
    reset_n     = 1'b0;
    model_reset();
    @(negedge clk);
    compare();
    @(negedge clk);
    clear_runs();
    reset_n = 1'b1;
    compare();
  endtask

  task automatic expect_runs(input string tag);
    check({tag, "_nruns"}, int'(rl_ph.size() >= exp_ph.size()), 1);
    for (int i = 0; i < exp_ph.size() && i < rl_ph.size(); i++) begin
      check($sformatf("%s_ph%0d", tag, i), rl_ph[i], exp_ph[i]);
      check($sformatf("%s_len%0d", tag, i), rl_len[i], exp_ln[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.ns_car  = 1'b0;
    bus.ew_car  = 1'b0;
    bus.ped_req = 1'b0;
    reset_n     = 1'b0;
    model_reset();
    clear_runs();

    // Reset with no demand: release at 150 ns, rest in NS green.
    #20;
    compare();
    #130;
    clear_runs();
    reset_n = 1'b1;
    compare();
    for (int i = 0; i < 50; i++) cycle(0, 0, 0);
    exp_ph = '{5};
    exp_ln = '{1};
    expect_runs("rest");
    check("rest_cur_phase", cur_ph, 0);
    check("rest_cur_len", cur_len, 50);

    // EW demand only: 0x4, 1x2, 2x1, then EW green rests.
    do_reset();
    for (int i = 0; i < 30; i++) cycle(0, 1, 0);
    exp_ph = '{5, 0, 1, 2};
    exp_ln = '{1, 4, 2, 1};
    expect_runs("ew_only");
    check("ew_only_rest", cur_ph, 3);

    // Both directions saturated: 10/2/1 alternating, 26-cycle period.
    do_reset();
    for (int i = 0; i < 60; i++) cycle(1, 1, 0);
    exp_ph = '{5, 0, 1, 2, 3, 4, 5, 0, 1};
    exp_ln = '{1, 10, 2, 1, 10, 2, 1, 10, 2};
    expect_runs("both");

    // One-cycle ped pulse at NS timer 1, no cars.
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0);
    exp_ph = '{5, 0, 1, 2, 6};
    exp_ln = '{1, 4, 2, 1, 3};
    expect_runs("ped");
    check("ped_cleared_rest", cur_ph, 3);

    // Ped press on the edge entering WALK_TO_EW is kept for the next crossing.
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    k = 0;
    while (bus.phase != 3'd2 && k < 20) begin
      cycle(0, 0, 0);
      k++;
    end
    check("reach_ar_to_ew", int'(bus.phase), 2);
    cycle(0, 0, 1);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0);
    exp_ph = '{5, 0, 1, 2, 6, 3, 4, 5, 7};
    exp_ln = '{1, 4, 2, 1, 3, 4, 2, 1, 3};
    expect_runs("ped_twice");
    check("ped_twice_rest", cur_ph, 0);

    // Asynchronous reset in the middle of EW yellow.
    do_reset();
    k = 0;
    while (bus.phase != 3'd4 && k < 60) begin
      cycle(1, 1, 0);
      k++;
    end
    check("reach_ew_yellow", int'(bus.phase), 4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare();
    @(negedge clk);
    clear_runs();
    reset_n = 1'b1;
    compare();
    for (int i = 0; i < 15; i++) cycle(1, 1, 0);
    exp_ph = '{5, 0, 1, 2};
    exp_ln = '{1, 10, 2, 1};
    expect_runs("async_rst");

    // Randomized sensors and button against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
